// File: rtl/wash_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine cycle controller.
//   - wash_state_t : controller state enum; its 3-bit encoding is what the
//                    controller exposes on state_o.
//   - DEF_*        : default values for the controller parameters.
// ---------------------------------------------------------------------------
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_DETERGENT = 3'd2,
        ST_WASH      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SPIN      = 3'd5,
        ST_FAULT     = 3'd6
    } wash_state_t;

    localparam int DEF_TIMER_W     = 16;
    localparam int DEF_RINSE_W     = 3;
    localparam int DEF_FAULT_TICKS = 1000;

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// wash_cycle_ctrl_if
// Bundles the sensor inputs, programme settings and actuator outputs of the
// wash cycle controller.
//   master : the appliance side (drives sensors/settings, observes actuators)
//   slave  : the controller (reads sensors/settings, drives actuators)
// Sensors/settings : start, door_close, filled, drained, detergent_added,
//                    pause, abort, wash_time, spin_time, rinse_count
// Actuators/status : door_lock, motor_on, fill_val_on, drain_val_on,
//                    water_wash, done, fault, state_o, rinse_left
// ---------------------------------------------------------------------------
interface wash_cycle_ctrl_if #(
    parameter int TIMER_W = wash_pkg::DEF_TIMER_W,
    parameter int RINSE_W = wash_pkg::DEF_RINSE_W
) ();

    logic               start;
    logic               door_close;
    logic               filled;
    logic               drained;
    logic               detergent_added;
    logic               pause;
    logic               abort;
    logic [TIMER_W-1:0] wash_time;
    logic [TIMER_W-1:0] spin_time;
    logic [RINSE_W-1:0] rinse_count;

    logic               door_lock;
    logic               motor_on;
    logic               fill_val_on;
    logic               drain_val_on;
    logic               water_wash;
    logic               done;
    logic               fault;
    logic [2:0]         state_o;
    logic [RINSE_W-1:0] rinse_left;

    modport master (
        output start, door_close, filled, drained, detergent_added,
               pause, abort, wash_time, spin_time, rinse_count,
        input  door_lock, motor_on, fill_val_on, drain_val_on, water_wash,
               done, fault, state_o, rinse_left
    );

    modport slave (
        input  start, door_close, filled, drained, detergent_added,
               pause, abort, wash_time, spin_time, rinse_count,
        output door_lock, motor_on, fill_val_on, drain_val_on, water_wash,
               done, fault, state_o, rinse_left
    );

endinterface

// File: rtl/wash_cycle_ctrl_timer.sv
// ---------------------------------------------------------------------------
// wash_timer
// Loadable down-counter used as the WASH/SPIN phase timer.
//   clk, reset  : clock, asynchronous active-high reset
//   i_load      : load i_load_val (wins over everything else)
//   i_load_val  : phase duration to load
//   i_hold      : freeze the count (pause, or not in a timed phase)
//   o_expire    : count == 1, i.e. the last unpaused cycle of the phase
// ---------------------------------------------------------------------------
module wash_timer #(
    parameter int TIMER_W = wash_pkg::DEF_TIMER_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_hold,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;

    // Count down towards 1 and stop there; the controller leaves the phase
    // on the cycle it sees 1, so the counter never needs to go to 0 or wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (!i_hold && (r_count > TIMER_W'(1))) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_expire = (r_count == TIMER_W'(1));

endmodule

// File: rtl/wash_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// wash_cycle_ctrl
// Washing-machine programme sequencer: fill, detergent, wash, optional rinse
// passes, drain and spin, with pause, abort and a fill/drain watchdog that
// latches a FAULT state until reset.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : wash_cycle_ctrl_if.slave carrying sensors, programme
//                settings (wash_time, spin_time, rinse_count) and actuator /
//                status outputs (door_lock, motor_on, valves, done, fault,
//                state_o, rinse_left)
// ---------------------------------------------------------------------------
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int TIMER_W     = DEF_TIMER_W,
    parameter int RINSE_W     = DEF_RINSE_W,
    parameter int FAULT_TICKS = DEF_FAULT_TICKS
) (
    input  logic            clk,
    input  logic            reset,
    wash_cycle_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] WD_LAST = TIMER_W'(FAULT_TICKS - 1);

    wash_state_t        r_state;
    wash_state_t        w_next;
    logic [TIMER_W-1:0] r_wash_dur;
    logic [TIMER_W-1:0] r_spin_dur;
    logic [RINSE_W-1:0] r_rinse_left;
    logic               r_rinse_pass;
    logic               r_abort_flag;
    logic               r_done;
    logic [TIMER_W-1:0] r_watchdog;

    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_hold;
    logic               w_expire;
    logic               w_set_abort;
    logic               w_done_set;
    logic               w_capture;
    logic               w_rinse_step;
    logic               w_wd_expired;
    logic               w_timed_phase;
    logic               w_watched_phase;

    logic w_door_lock, w_motor_on, w_fill_val_on, w_drain_val_on;
    logic w_water_wash, w_fault;

    assign w_timed_phase   = (r_state == ST_WASH) || (r_state == ST_SPIN);
    assign w_watched_phase = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign w_wd_expired    = w_watched_phase && (r_watchdog == WD_LAST);
    assign w_hold          = bus.pause || !w_timed_phase;
    assign w_capture       = (r_state == ST_IDLE) && bus.start && bus.door_close;
    assign w_rinse_step    = (r_state == ST_DRAIN) && (w_next == ST_FILL);

    wash_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_hold     (w_hold),
        .o_expire   (w_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Within each state the watchdog is tested first,
    // then abort, then the normal exit; pause only matters through the
    // timer expiry test. In FILL/DRAIN the watchdog only fires when the
    // normal exit sensor is not already high on that cycle. The timer is
    // loaded on the transition into WASH or SPIN so the first cycle of the
    // phase already sees the full duration.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_val  = r_wash_dur;
        w_set_abort = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && bus.door_close) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_wd_expired && !bus.filled) begin
                    w_next = ST_FAULT;
                end else if (bus.abort) begin
                    w_next      = ST_DRAIN;
                    w_set_abort = 1'b1;
                end else if (bus.filled) begin
                    if (r_rinse_pass || bus.detergent_added) begin
                        w_next = ST_WASH;
                        w_load = 1'b1;
                    end else begin
                        w_next = ST_DETERGENT;
                    end
                end
            end
            ST_DETERGENT: begin
                if (bus.abort) begin
                    w_next      = ST_DRAIN;
                    w_set_abort = 1'b1;
                end else if (bus.detergent_added) begin
                    w_next = ST_WASH;
                    w_load = 1'b1;
                end
            end
            ST_WASH: begin
                if (bus.abort) begin
                    w_next      = ST_DRAIN;
                    w_set_abort = 1'b1;
                end else if (w_expire && !bus.pause) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_wd_expired && !bus.drained) begin
                    w_next = ST_FAULT;
                end else begin
                    w_set_abort = bus.abort;
                    if (bus.drained) begin
                        if (r_abort_flag || bus.abort) begin
                            w_next = ST_IDLE;
                        end else if (r_rinse_left != '0) begin
                            w_next = ST_FILL;
                        end else begin
                            w_next     = ST_SPIN;
                            w_load     = 1'b1;
                            w_load_val = r_spin_dur;
                        end
                    end
                end
            end
            ST_SPIN: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_expire && !bus.pause) begin
                    w_next     = ST_IDLE;
                    w_done_set = 1'b1;
                end
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Watchdog: restarts from zero on every state change and only counts
    // while waiting on the level sensors in FILL or DRAIN. It stops at
    // WD_LAST because leaving the state clears it again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_watchdog <= '0;
        end else if (w_next != r_state) begin
            r_watchdog <= '0;
        end else if (w_watched_phase) begin
            r_watchdog <= r_watchdog + TIMER_W'(1);
        end else begin
            r_watchdog <= '0;
        end
    end

    // Programme settings are captured once at start. A zero duration is
    // stored as 1 so a phase always lasts at least one cycle and the timer
    // never has to count from 0. The rinse counter only steps on a real
    // DRAIN->FILL rinse transition, which requires it to be non-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wash_dur   <= '0;
            r_spin_dur   <= '0;
            r_rinse_left <= '0;
            r_rinse_pass <= 1'b0;
            r_abort_flag <= 1'b0;
        end else if (w_capture) begin
            r_wash_dur   <= (bus.wash_time == '0) ? TIMER_W'(1) : bus.wash_time;
            r_spin_dur   <= (bus.spin_time == '0) ? TIMER_W'(1) : bus.spin_time;
            r_rinse_left <= bus.rinse_count;
            r_rinse_pass <= 1'b0;
            r_abort_flag <= 1'b0;
        end else begin
            if (w_rinse_step) begin
                r_rinse_left <= r_rinse_left - RINSE_W'(1);
                r_rinse_pass <= 1'b1;
            end
            if (w_set_abort) begin
                r_abort_flag <= 1'b1;
            end
        end
    end

    // Completion pulse, registered so it appears in the first IDLE cycle
    // after a normally finished spin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

    // Moore output decode from the registered state. Pause gates the motor
    // directly, and in FAULT the door stays locked until the tub is empty.
    always_comb begin
        w_door_lock    = 1'b0;
        w_motor_on     = 1'b0;
        w_fill_val_on  = 1'b0;
        w_drain_val_on = 1'b0;
        w_water_wash   = 1'b0;
        w_fault        = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_door_lock   = 1'b1;
                w_fill_val_on = 1'b1;
            end
            ST_DETERGENT: begin
                w_door_lock = 1'b1;
            end
            ST_WASH: begin
                w_door_lock  = 1'b1;
                w_water_wash = 1'b1;
                w_motor_on   = !bus.pause;
            end
            ST_DRAIN: begin
                w_door_lock    = 1'b1;
                w_drain_val_on = 1'b1;
            end
            ST_SPIN: begin
                w_door_lock    = 1'b1;
                w_drain_val_on = 1'b1;
                w_motor_on     = !bus.pause;
            end
            ST_FAULT: begin
                w_drain_val_on = 1'b1;
                w_fault        = 1'b1;
                w_door_lock    = !bus.drained;
            end
            default: begin
                w_door_lock = 1'b0;
            end
        endcase
    end

    assign bus.door_lock    = w_door_lock;
    assign bus.motor_on     = w_motor_on;
    assign bus.fill_val_on  = w_fill_val_on;
    assign bus.drain_val_on = w_drain_val_on;
    assign bus.water_wash   = w_water_wash;
    assign bus.fault        = w_fault;
    assign bus.done         = r_done;
    assign bus.state_o      = r_state;
    assign bus.rinse_left   = r_rinse_left;

endmodule
